// File: rtl/commit_defs_pkg.sv
// Shared definitions for the ROB commit stage: instruction field positions,
// opcode constants, fixed destination registers, FSM encodings and the decode record.
// Optional statistics counters are enabled by COMMIT_STATS_EN (see rob_commit_unit).
package commit_defs_pkg;

  // Instruction field layout: opcode = instr[31:27], rd = instr[26:22]
  localparam int RF_ADDR_W = 5;
  localparam int RD_LSB    = 22;
  localparam int OPC_LSB   = 27;
  localparam int OPC_W     = 5;
  localparam int DEC_W     = 32 - RD_LSB;  // bits the decoder needs (rd + opcode)

  // Opcodes that change decode behaviour; everything else writes rd
  localparam logic [OPC_W-1:0] OPC_J    = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_BNE  = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_JAL  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_JR   = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_BLT  = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_SW   = 5'b00111;
  localparam logic [OPC_W-1:0] OPC_SETX = 5'b10101;
  localparam logic [OPC_W-1:0] OPC_BEX  = 5'b10110;

  // Implicit destinations
  localparam logic [RF_ADDR_W-1:0] LINK_REG   = 5'd31;
  localparam logic [RF_ADDR_W-1:0] STATUS_REG = 5'd30;

  // Commit FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_COMMIT = 2'd1;
  localparam logic [1:0] ST_STREQ  = 2'd2;

  typedef struct packed {
    logic                 is_store;
    logic                 has_dest;
    logic [RF_ADDR_W-1:0] dest_addr;
  } dec_t;

endpackage

// File: rtl/commit_decode.sv
// Combinational destination decode of the instruction at the ROB head.
// Input is the upper instruction slice holding rd and opcode; output is the
// store flag, whether a register is written, and which register.
module commit_decode
  import commit_defs_pkg::*;
(
  input  logic [DEC_W-1:0] instr_hi,
  output dec_t             dec
);

  logic [OPC_W-1:0]     opc;
  logic [RF_ADDR_W-1:0] rd;

  assign opc = instr_hi[OPC_LSB-RD_LSB +: OPC_W];
  assign rd  = instr_hi[0 +: RF_ADDR_W];

  // Classify opcode: stores and branches/jumps have no register destination
  always_comb begin
    dec.is_store  = 1'b0;
    dec.has_dest  = 1'b1;
    dec.dest_addr = rd;
    case (opc)
      OPC_SW: begin
        dec.is_store  = 1'b1;
        dec.has_dest  = 1'b0;
        dec.dest_addr = '0;
      end
      OPC_J, OPC_BNE, OPC_JR, OPC_BLT, OPC_BEX: begin
        dec.has_dest  = 1'b0;
        dec.dest_addr = '0;
      end
      OPC_JAL:  dec.dest_addr = LINK_REG;
      OPC_SETX: dec.dest_addr = STATUS_REG;
      default: ;
    endcase
  end

endmodule

// File: rtl/rob_commit_unit.sv
// In-order retirement: pops the ROB head one cycle after it is seen ready (reg ops),
// or after the store queue accepts the release (stores). Retires at most 1 per 2 cycles.
// Optional counters stat_retired/stat_stall are present only with COMMIT_STATS_EN defined.
module rob_commit_unit
  import commit_defs_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rob_is_empty,
  input  logic [31:0]          rob_head_instr,
  input  logic [31:0]          rob_head_val,
  input  logic                 rob_head_ready,
  output logic                 rob_pop,
  input  logic                 flush,
  output logic                 rf_wEn,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 st_valid,
  input  logic                 st_ready,
  output logic                 retire_pulse,
  output logic [31:0]          retired_instr
`ifdef COMMIT_STATS_EN
  ,
  output logic [31:0]          stat_retired,
  output logic [31:0]          stat_stall
`endif
);

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [31:0]          hold_instr;
  logic [31:0]          hold_val;
  logic [RF_ADDR_W-1:0] hold_dest;
  logic                 hold_wen;

  dec_t                 head_dec;
  logic                 head_valid;
  logic                 kill;
  logic                 in_commit;
  logic                 in_streq;
  logic                 retire;
  logic                 capture;

  commit_decode u_decode (
    .instr_hi (rob_head_instr[31:RD_LSB]),
    .dec      (head_dec)
  );

  // A zero instruction word is a bubble even if the ROB claims it is ready
  assign head_valid = ~rob_is_empty & rob_head_ready & (|rob_head_instr);
  // Reset behaves like flush on the cycle it is asserted so nothing leaks out
  assign kill       = flush | reset;
  assign in_commit  = (state == ST_COMMIT);
  assign in_streq   = (state == ST_STREQ);
  assign capture    = (state == ST_IDLE) & head_valid & ~flush;

  // Next-state: flush always returns to IDLE, abandoning any in-flight commit
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (head_valid) state_nxt = head_dec.is_store ? ST_STREQ : ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      ST_STREQ:  if (st_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // State register and head hold registers; later head changes are ignored
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      hold_instr <= '0;
      hold_val   <= '0;
      hold_dest  <= '0;
      hold_wen   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        hold_instr <= rob_head_instr;
        hold_val   <= rob_head_val;
        hold_dest  <= head_dec.dest_addr;
        hold_wen   <= head_dec.has_dest & (|head_dec.dest_addr);
      end
    end
  end

  // Outputs come only from hold registers and are gated by flush/reset
  always_comb begin
    retire        = ~kill & (in_commit | (in_streq & st_ready));
    rob_pop       = retire;
    retire_pulse  = retire;
    st_valid      = ~kill & in_streq;
    rf_wEn        = ~kill & in_commit & hold_wen;
    rf_waddr      = in_commit ? hold_dest : '0;
    rf_wdata      = in_commit ? hold_val  : '0;
    retired_instr = retire ? hold_instr : '0;
  end

`ifdef COMMIT_STATS_EN
  logic stall;
  assign stall = ((state == ST_IDLE) & ~rob_is_empty & ~rob_head_ready) |
                 (in_streq & ~st_ready);

  // Free-running counters, cleared only by reset and wrapping naturally
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_retired <= '0;
      stat_stall   <= '0;
    end else begin
      if (retire) stat_retired <= stat_retired + 32'd1;
      if (stall)  stat_stall   <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit with a scoreboard of expected retirements.
// Stimulus pushes expected retirements; a monitor pops and compares on each retire.
// Builds with or without COMMIT_STATS_EN.
module tb_rob_commit_unit;

  logic        clock;
  logic        reset;
  logic        rob_is_empty;
  logic [31:0] rob_head_instr;
  logic [31:0] rob_head_val;
  logic        rob_head_ready;
  logic        rob_pop;
  logic        flush;
  logic        rf_wEn;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        st_valid;
  logic        st_ready;
  logic        retire_pulse;
  logic [31:0] retired_instr;
`ifdef COMMIT_STATS_EN
  logic [31:0] stat_retired;
  logic [31:0] stat_stall;
`endif

  rob_commit_unit dut (
    .clock          (clock),
    .reset          (reset),
    .rob_is_empty   (rob_is_empty),
    .rob_head_instr (rob_head_instr),
    .rob_head_val   (rob_head_val),
    .rob_head_ready (rob_head_ready),
    .rob_pop        (rob_pop),
    .flush          (flush),
    .rf_wEn         (rf_wEn),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .retire_pulse   (retire_pulse),
    .retired_instr  (retired_instr)
`ifdef COMMIT_STATS_EN
    ,
    .stat_retired   (stat_retired),
    .stat_stall     (stat_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [4:0] rd);
    return {opc, rd, 22'h000ABC};
  endfunction

  // Monitor: every retirement must match the oldest expected entry
  always @(negedge clock) begin
    if (!reset) begin
      chk("pop_eq_retire", {31'd0, rob_pop}, {31'd0, retire_pulse});
      if (retire_pulse === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_pop", 32'd1, 32'd0);
        end else begin
          mon_e = q.pop_front();
          chk("retired_instr", retired_instr, mon_e.instr);
          chk("rf_wEn", {31'd0, rf_wEn}, {31'd0, mon_e.wen});
          if (mon_e.wen) begin
            chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, mon_e.waddr});
            chk("rf_wdata", rf_wdata, mon_e.wdata);
          end
        end
      end
    end
  end

  task automatic present(input logic [31:0] instr, input logic [31:0] val, input logic rdy);
    rob_is_empty   = 1'b0;
    rob_head_instr = instr;
    rob_head_val   = val;
    rob_head_ready = rdy;
  endtask

  task automatic go_empty();
    rob_is_empty   = 1'b1;
    rob_head_instr = '0;
    rob_head_val   = '0;
    rob_head_ready = 1'b0;
  endtask

  task automatic expect_retire(input logic [31:0] instr, input logic wen,
                               input logic [4:0] waddr, input logic [31:0] wdata);
    exp_t e;
    e.instr = instr;
    e.wen   = wen;
    e.waddr = waddr;
    e.wdata = wdata;
    q.push_back(e);
  endtask

  // Count negedges until pop (bounded); the ROB drops its head at the pop edge
  task automatic wait_pop(input string name, input int req_lat);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clock);
      n++;
      if (rob_pop === 1'b1) seen = 1'b1;
    end
    if (!seen) n = 99;
    chk({name, "_pop_latency"}, n, req_lat);
    @(posedge clock);
    #1 go_empty();
  endtask

  task automatic commit_op(input string name, input logic [31:0] instr, input logic [31:0] val,
                           input logic wen, input logic [4:0] waddr);
    expect_retire(instr, wen, waddr, val);
    present(instr, val, 1'b1);
    wait_pop(name, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    st_ready = 1'b0;
    go_empty();

    // 1: reset two cycles, then ten idle cycles with an empty ROB
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_ctrl", {28'd0, rob_pop, rf_wEn, st_valid, retire_pulse}, 32'd0);
      chk("idle_data", rf_wdata | retired_instr | {27'd0, rf_waddr}, 32'd0);
    end
    @(posedge clock);
    #1;

    // 2: register op rd=5
    commit_op("add_rd5", mk(5'b00000, 5'd5), 32'hDEADBEEF, 1'b1, 5'd5);

    // 3: head not ready for 4 cycles, then ready
    present(mk(5'b00000, 5'd9), 32'h0000_0011, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("notready_no_pop", {31'd0, rob_pop}, 32'd0);
    end
    @(posedge clock);
    #1;
    expect_retire(mk(5'b00000, 5'd9), 1'b1, 5'd9, 32'h0000_0011);
    rob_head_ready = 1'b1;
    wait_pop("ready_rise", 2);

    // 4: store with store queue stalled; head changes mid-request must be ignored
    expect_retire(mk(5'b00111, 5'd3), 1'b0, 5'd0, 32'd0);
    present(mk(5'b00111, 5'd3), 32'h0000_0055, 1'b1);
    @(negedge clock);
    chk("sw_first_cycle_stv", {31'd0, st_valid}, 32'd0);
    @(negedge clock);
    chk("sw_stv_rise", {31'd0, st_valid}, 32'd1);
    @(posedge clock);
    #1 present(mk(5'b00000, 5'd4), 32'h0BAD_0BAD, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("sw_stv_held", {31'd0, st_valid}, 32'd1);
      chk("sw_no_pop", {31'd0, rob_pop}, 32'd0);
      chk("sw_no_wen", {31'd0, rf_wEn}, 32'd0);
    end
    @(posedge clock);
    #1 st_ready = 1'b1;
    @(negedge clock);
    chk("sw_pop", {31'd0, rob_pop}, 32'd1);
    chk("sw_pop_no_wen", {31'd0, rf_wEn}, 32'd0);
    @(posedge clock);
    #1 st_ready = 1'b0;
    go_empty();
    @(negedge clock);
    chk("sw_stv_drop", {31'd0, st_valid}, 32'd0);
    @(posedge clock);
    #1;

    // 5: rd=0 writes nothing; jal/setx use fixed registers; branch writes nothing
    commit_op("add_rd0", mk(5'b00000, 5'd0), 32'd7,          1'b0, 5'd0);
    commit_op("jal",     mk(5'b00011, 5'd7), 32'h0000_1234,  1'b1, 5'd31);
    commit_op("setx",    mk(5'b10101, 5'd2), 32'h0000_00A5,  1'b1, 5'd30);
    commit_op("bne",     mk(5'b00010, 5'd6), 32'd9,          1'b0, 5'd0);

    // 6: flush with st_ready in the same ST_REQ cycle -> no release, no pop
    present(mk(5'b00111, 5'd1), 32'h0000_0077, 1'b1);
    @(negedge clock);
    @(negedge clock);
    chk("fl_stv_before", {31'd0, st_valid}, 32'd1);
    @(posedge clock);
    #1;
    flush    = 1'b1;
    st_ready = 1'b1;
    @(negedge clock);
    chk("flush_stv", {31'd0, st_valid}, 32'd0);
    chk("flush_pop", {31'd0, rob_pop}, 32'd0);
    @(posedge clock);
    #1;
    flush    = 1'b0;
    st_ready = 1'b0;
    go_empty();
    @(negedge clock);
    chk("post_flush_idle_stv", {31'd0, st_valid}, 32'd0);
    @(posedge clock);
    #1;
    commit_op("after_flush", mk(5'b00000, 5'd12), 32'h00C0_FFEE, 1'b1, 5'd12);

    repeat (3) @(negedge clock);
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
